// File: rtl/cdc_handshake_rx.sv
// cdc_handshake_rx: 4-phase req/ack receiver with one-entry valid/ready holding register.
// Define CDC_HANDSHAKE_RX_TIMEOUT_EN to add the ack timeout counter and ERR state.
module cdc_handshake_rx #(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_async,
    input  logic [WIDTH-1:0] data_async,
    output logic             ack,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic [15:0]      xfer_count,
    output logic             timeout
);
    typedef enum logic [1:0] {IDLE, ACK, ERR} state_t;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic             ack_q, ack_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [15:0]      xfer_count_q, xfer_count_d;
    logic             req_s, capture;

    assign req_s   = sync2_q;
    assign capture = (state_q == IDLE) && req_s && (!out_valid_q || out_ready);

`ifdef CDC_HANDSHAKE_RX_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d, to_err;

    // cnt_q counts edges already spent in ACK, so hitting the limit on this edge means cnt_q == limit-1
    assign to_err = (state_q == ACK) && req_s && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = capture ? ACK : to_err ? ERR : (state_q != IDLE && !req_s) ? IDLE : state_q;
    end

    always_comb begin
        cnt_d     = capture ? '0 : (state_q == ACK && req_s) ? cnt_q + CW'(1) : cnt_q;
        timeout_d = timeout_q | to_err;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    always_comb begin
        state_d = capture ? ACK : (state_q == ACK && !req_s) ? IDLE : state_q;
    end

    assign timeout = 1'b0;
`endif

    always_comb begin
        ack_d        = (state_d == ACK);
        out_valid_d  = capture ? 1'b1 : (out_valid_q && out_ready) ? 1'b0 : out_valid_q;
        out_data_d   = capture ? data_async : out_data_q;
        xfer_count_d = xfer_count_q + {15'd0, capture};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            ack_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= req_async;
            sync2_q      <= sync1_q;
            ack_q        <= ack_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign ack        = ack_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign xfer_count = xfer_count_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_cdc_handshake_rx.sv
// tb_cdc_handshake_rx: directed self-checking bench for cdc_handshake_rx.
module tb_cdc_handshake_rx;
    logic        clk = 1'b0;
    logic        reset_n, req_async, out_ready;
    logic [15:0] data_async;
    logic        ack, out_valid, busy, timeout;
    logic [15:0] out_data, xfer_count;
    int          checks = 0;
    int          errors = 0;

    cdc_handshake_rx #(.WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n), .req_async(req_async), .data_async(data_async),
        .ack(ack), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .xfer_count(xfer_count), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; req_async = 1'b0; out_ready = 1'b0; data_async = 16'h0;
        step(2);
        chk("rst_ack", ack, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", xfer_count, 0);
        chk("rst_timeout", timeout, 0);
        reset_n = 1'b1;

        out_ready = 1'b1; data_async = 16'hA5C3; req_async = 1'b1;
        step(2);
        chk("basic_ack_early", ack, 0);
        step(1);
        chk("basic_ack", ack, 1);
        chk("basic_valid", out_valid, 1);
        chk("basic_data", out_data, 16'hA5C3);
        chk("basic_busy", busy, 1);
        req_async = 1'b0;
        step(2);
        chk("basic_ack_hold", ack, 1);
        chk("basic_consumed", out_valid, 0);
        step(1);
        chk("basic_release", ack, 0);
        chk("basic_idle", busy, 0);
        chk("basic_count", xfer_count, 1);

        out_ready = 1'b0; data_async = 16'h1111; req_async = 1'b1;
        step(3);
        chk("bp_first_ack", ack, 1);
        chk("bp_first_data", out_data, 16'h1111);
        req_async = 1'b0;
        step(3);
        chk("bp_first_release", ack, 0);
        chk("bp_held", out_valid, 1);
        data_async = 16'h2222; req_async = 1'b1;
        step(4);
        chk("bp_ack_stall", ack, 0);
        chk("bp_data_stall", out_data, 16'h1111);
        chk("bp_busy_stall", busy, 0);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        chk("bp_swap_data", out_data, 16'h2222);
        chk("bp_swap_valid", out_valid, 1);
        chk("bp_swap_ack", ack, 1);
        req_async = 1'b0;
        step(3);
        chk("bp_release", ack, 0);
        chk("bp_count", xfer_count, 3);
        out_ready = 1'b1;
        step(1);
        chk("bp_drain", out_valid, 0);

        for (int i = 1; i <= 4; i++) begin
            data_async = 16'(i); req_async = 1'b1;
            step(3);
            chk("b2b_ack", ack, 1);
            chk("b2b_data", out_data, 32'(i));
            chk("b2b_valid", out_valid, 1);
            req_async = 1'b0;
            step(1);
            chk("b2b_once", out_valid, 0);
            step(2);
            chk("b2b_release", ack, 0);
        end
        chk("b2b_count", xfer_count, 7);

        force dut.xfer_count_q = 16'hFFFF;
        step(1);
        release dut.xfer_count_q;
        step(1);
        chk("wrap_preload", xfer_count, 16'hFFFF);
        data_async = 16'h5A5A; req_async = 1'b1;
        step(3);
        chk("wrap_count", xfer_count, 0);
        chk("wrap_data", out_data, 16'h5A5A);
        req_async = 1'b0;
        step(3);

        data_async = 16'hBEEF; req_async = 1'b1;
        step(3);
        chk("rmid_ack_before", ack, 1);
        reset_n = 1'b0;
        step(1);
        chk("rmid_ack", ack, 0);
        chk("rmid_valid", out_valid, 0);
        chk("rmid_busy", busy, 0);
        chk("rmid_data", out_data, 0);
        chk("rmid_count", xfer_count, 0);
        reset_n = 1'b1;
        step(2);
        chk("rmid_resync", ack, 0);
        step(1);
        chk("rmid_recapture_ack", ack, 1);
        chk("rmid_recapture_data", out_data, 16'hBEEF);
        chk("rmid_recapture_count", xfer_count, 1);
        req_async = 1'b0;
        step(3);
        chk("rmid_release", ack, 0);

`ifdef CDC_HANDSHAKE_RX_TIMEOUT_EN
        data_async = 16'hCAFE; req_async = 1'b1;
        step(3);
        chk("to_enter", ack, 1);
        step(7);
        chk("to_ack_hold", ack, 1);
        chk("to_not_yet", timeout, 0);
        step(1);
        chk("to_ack_drop", ack, 0);
        chk("to_flag", timeout, 1);
        chk("to_err_busy", busy, 1);
        req_async = 1'b0;
        step(3);
        chk("to_idle", busy, 0);
        chk("to_sticky", timeout, 1);
        chk("to_ack_low", ack, 0);
`else
        data_async = 16'hCAFE; req_async = 1'b1;
        step(15);
        chk("nto_ack_hold", ack, 1);
        chk("nto_timeout", timeout, 0);
        req_async = 1'b0;
        step(3);
        chk("nto_release", ack, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
